playfield_buf: RTL and testbench
================================

Name: playfield_buf

Overview:
- Downstream consumer of the random line generator. Captures each new 640-bit playfield line into a ring buffer of ROWS lines, giving a vertically scrolling playfield.
- Provides a registered row read port for the display path.
- Checks the player's pixel against the row at the player's row position and raises a sticky collision flag.
- Bit encoding: 1 = open, 0 = obstacle.

Parameters:
- WIDTH, 640, bits per line; must match the generator's line width.
- ROWS, 16, number of stored lines (power of two, ≥2).
- PLAYER_ROW, ROWS-1, logical row the player occupies (0 = newest/top).

Ports:
- clk_line  in  1  line clock; one line per scroll_en_i pulse.
- rst_i  in  1  asynchronous, active-low reset.
- line_i  in  WIDTH  incoming line from generator.
- scroll_en_i  in  1  write line_i as new row 0 and shift all rows down by one.
- rd_row_i  in  $clog2(ROWS)  logical row to read.
- rd_line_o  out  WIDTH  registered read data.
- player_x_i  in  10  player pixel column.
- clr_i  in  1  clear collision flag.
- collide_o  out  1  sticky collision flag.
- fill_o  out  $clog2(ROWS)+1  number of valid rows, saturating at ROWS.
- full_o  out  1  fill_o == ROWS.

Behaviour:
- Reset (async, rst_i=0):
  - all storage = all ones; head pointer = 0; fill_o = 0.
  - rd_line_o = all ones; collide_o = 0.
- Storage and pointers:
  - Physical ring of ROWS words; head points to the next write slot.
  - Logical row r maps to physical (head-1-r) mod ROWS. Row 0 = newest, row ROWS-1 = oldest.
- Scroll (scroll_en_i=1 at posedge):
  - mem[head] <= line_i; head <= head+1 mod ROWS (wraps ROWS-1 -> 0).
  - fill_o increments, saturating at ROWS.
  - Once full, the oldest row is overwritten.
- Read:
  - rd_line_o <= logical row rd_row_i evaluated on the pre-edge state; 1-cycle latency.
  - Read coincident with a scroll returns the pre-scroll contents/mapping.
  - A row with r ≥ fill_o (never written) reads all ones.
- Collision, evaluated every cycle:
  - Target row = the row at logical PLAYER_ROW after this edge.
  - With scroll_en_i=1: target is logical PLAYER_ROW-1 pre-edge, or line_i itself when PLAYER_ROW=0.
  - With scroll_en_i=0: target is logical PLAYER_ROW pre-edge.
  - hit = target valid (post-edge fill > PLAYER_ROW) AND player_x_i < WIDTH AND target[player_x_i]==0.
  - collide_o <= hit | (collide_o & ~clr_i). Set wins over a simultaneous clear.
  - player_x_i ≥ WIDTH never hits.
- Reset mid-operation: immediate return to reset state; no partial write survives.
- No other state machine. The write path is a single-cycle pointer update; the read and collision paths are mux + register.

Decomposition:
- Shared game package holds:
  - LINE_WIDTH = 640 constant, shared with the generator.
  - Bit-encoding constants PIX_OPEN = 1, PIX_BLOCK = 0.
  - Helper function logical_to_phys(head, r).
- One natural sub-module, playfield_ring:
  - owns the storage array, head, fill, write and logical-index mapping;
  - exposes two combinational logical read taps (display, collision).
- Top level adds the read register, collision logic and flag.

Test Plan:
- Reset then 3 scrolls of lines A, B, C (ROWS=16):
  - read rows 0,1,2 -> C, B, A on the following cycles;
  - row 3 -> all ones; fill_o = 3; full_o = 0.
- 20 scrolls of distinct lines L0..L19:
  - fill_o = 16, full_o = 1;
  - row 0 = L19, row 15 = L4 (wrap verified);
  - L0–L3 unreadable.
- Read row 0 in the same cycle as a scroll of X when row 0 = Y -> rd_line_o = Y; next read of row 0 -> X.
- Buffer full, row 14 has bit 100 = 0, player_x_i = 100, scroll_en_i pulse:
  - collide_o = 1 one cycle later;
  - holds after 5 idle cycles;
  - clr_i pulse -> 0, provided no other 0 bit sits under the player.
- collide_o = 1, then clr_i and a new hit in the same cycle -> collide_o stays 1. player_x_i = 700 over an all-zero row -> no set.
- Assert rst_i=0 asynchronously mid-stream with collide_o = 1, fill_o = 9:
  - outputs go to reset values without waiting for a clock edge;
  - after release, all rows read all ones.

Source files
------------

// File: rtl/playfield_pkg.sv
// Shared game package for the line generator and the playfield buffer.
//   LINE_WIDTH       - bits per playfield line, common to generator and buffer
//   PIX_OPEN/BLOCK   - pixel encoding (1 = open, 0 = obstacle)
//   logical_to_phys  - maps a logical row (0 = newest) to a physical ring slot
package playfield_pkg;

    localparam int   LINE_WIDTH = 640;
    localparam logic PIX_OPEN   = 1'b1;
    localparam logic PIX_BLOCK  = 1'b0;

    // head is the next write slot, so the newest line sits at head-1.
    // rows is a power of two, so the modulo reduces to a mask.
    function automatic int unsigned logical_to_phys(input int unsigned head,
                                                    input int unsigned r,
                                                    input int unsigned rows);
        return (head + rows - 1 - r) & (rows - 1);
    endfunction

endpackage

// File: rtl/playfield_ring.sv
// Ring buffer of ROWS playfield lines with logical (newest-first) addressing.
//   clk_line     - line clock
//   rst_i        - asynchronous, active-low reset
//   line_i       - line written as the new row 0 when scroll_en_i is high
//   scroll_en_i  - write line_i and advance the head pointer
//   disp_row_i   - logical row for the display tap
//   disp_line_o  - combinational display tap (all ones if row never written)
//   coll_row_i   - logical row for the collision tap
//   coll_line_o  - combinational collision tap (all ones if row never written)
//   fill_o       - number of valid rows, saturating at ROWS
//   full_o       - fill_o == ROWS
module playfield_ring
    import playfield_pkg::*;
#(
    parameter  int WIDTH  = LINE_WIDTH,
    parameter  int ROWS   = 16,
    localparam int PTR_W  = $clog2(ROWS),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic              clk_line,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  line_i,
    input  logic              scroll_en_i,
    input  logic [PTR_W-1:0]  disp_row_i,
    output logic [WIDTH-1:0]  disp_line_o,
    input  logic [PTR_W-1:0]  coll_row_i,
    output logic [WIDTH-1:0]  coll_line_o,
    output logic [FILL_W-1:0] fill_o,
    output logic              full_o
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ROWS);

    logic [WIDTH-1:0]  mem [ROWS];
    logic [PTR_W-1:0]  head;
    logic [FILL_W-1:0] fill;
    logic [PTR_W-1:0]  disp_phys;
    logic [PTR_W-1:0]  coll_phys;

    // NOTE: the storage array sits under the async reset on purpose: every
    // slot must read all ones straight after reset, so it cannot be a RAM
    // macro without a separate clear sequence.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_line or negedge rst_i) begin
        if (!rst_i) begin
            head <= '0;
            fill <= '0;
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '1;
            end
        end else if (scroll_en_i) begin
            mem[head] <= line_i;
            head      <= head + PTR_W'(1);
            if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    assign disp_phys = PTR_W'(logical_to_phys(32'(head), 32'(disp_row_i), ROWS));
    assign coll_phys = PTR_W'(logical_to_phys(32'(head), 32'(coll_row_i), ROWS));

    // Rows at or beyond the fill level were never written since reset and
    // present as fully open, whatever the slot holds.
    assign disp_line_o = ({1'b0, disp_row_i} < fill) ? mem[disp_phys] : '1;
    assign coll_line_o = ({1'b0, coll_row_i} < fill) ? mem[coll_phys] : '1;

    assign fill_o = fill;
    assign full_o = (fill == FILL_MAX);

endmodule

// File: rtl/playfield_buf.sv
// Vertically scrolling playfield buffer with display read port and a sticky
// player collision flag.
//   clk_line     - line clock; one line per scroll_en_i pulse
//   rst_i        - asynchronous, active-low reset
//   line_i       - incoming line from the generator
//   scroll_en_i  - store line_i as row 0, older rows move down one
//   rd_row_i     - logical row to read (0 = newest)
//   rd_line_o    - registered read data, 1-cycle latency, pre-edge contents
//   player_x_i   - player pixel column
//   clr_i        - clear the collision flag (a new hit wins)
//   collide_o    - sticky collision flag
//   fill_o       - valid rows, saturating at ROWS
//   full_o       - fill_o == ROWS
module playfield_buf
    import playfield_pkg::*;
#(
    parameter  int WIDTH      = LINE_WIDTH,
    parameter  int ROWS       = 16,
    parameter  int PLAYER_ROW = ROWS - 1,
    localparam int PTR_W      = $clog2(ROWS),
    localparam int FILL_W     = PTR_W + 1
) (
    input  logic              clk_line,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  line_i,
    input  logic              scroll_en_i,
    input  logic [PTR_W-1:0]  rd_row_i,
    output logic [WIDTH-1:0]  rd_line_o,
    input  logic [9:0]        player_x_i,
    input  logic              clr_i,
    output logic              collide_o,
    output logic [FILL_W-1:0] fill_o,
    output logic              full_o
);

    // The collision target is the row under the player after this edge.
    // A scroll moves logical row PLAYER_ROW-1 into the player's row.
    localparam logic [PTR_W-1:0] ROW_NOW  = PTR_W'(PLAYER_ROW);
    localparam logic [PTR_W-1:0] ROW_PREV = PTR_W'((PLAYER_ROW + ROWS - 1) % ROWS);

    logic [WIDTH-1:0] disp_line;
    logic [WIDTH-1:0] coll_line;
    logic [PTR_W-1:0] coll_row;
    logic [WIDTH-1:0] target;
    logic             x_in_range;
    logic [9:0]       x_idx;
    logic             hit;

    assign coll_row = scroll_en_i ? ROW_PREV : ROW_NOW;

    playfield_ring #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS)
    ) u_ring (
        .clk_line    (clk_line),
        .rst_i       (rst_i),
        .line_i      (line_i),
        .scroll_en_i (scroll_en_i),
        .disp_row_i  (rd_row_i),
        .disp_line_o (disp_line),
        .coll_row_i  (coll_row),
        .coll_line_o (coll_line),
        .fill_o      (fill_o),
        .full_o      (full_o)
    );

    // Validity of the target needs no separate term: the ring returns all
    // ones for unwritten rows, and the post-edge fill exceeds PLAYER_ROW
    // exactly when the selected pre-edge row is already valid. With
    // PLAYER_ROW == 0 a scrolling line_i is always valid.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        target = coll_line;
        if (scroll_en_i && (PLAYER_ROW == 0)) begin
            target = line_i;
        end
    end

    assign x_in_range = int'(player_x_i) < WIDTH;
    assign x_idx      = x_in_range ? player_x_i : '0;
    assign hit        = x_in_range && (target[x_idx] == PIX_BLOCK);

    always_ff @(posedge clk_line or negedge rst_i) begin
        if (!rst_i) begin
            rd_line_o <= '1;
            collide_o <= 1'b0;
        end else begin
            rd_line_o <= disp_line;
            collide_o <= hit | (collide_o & ~clr_i);
        end
    end

endmodule

// File: tb/tb_playfield_buf.sv
module tb_playfield_buf;

    localparam int W = 640;

    typedef enum int {K_RD, K_FILL, K_FULL, K_COLL, K_COLL2, K_FILL2} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [W-1:0] exp;
        string       name;
    } exp_t;

    logic          clk_line = 1'b0;
    logic          rst_i    = 1'b1;
    logic [W-1:0]  line_i   = '0;
    logic          scroll_en_i = 1'b0;
    logic [3:0]    rd_row_i = '0;
    logic [9:0]    player_x_i = 10'd1023;
    logic          clr_i    = 1'b0;

    logic [W-1:0]  rd_line_o, rd_line2;
    logic          collide_o, collide2;
    logic [4:0]    fill_o, fill2;
    logic          full_o, full2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [W-1:0] ones = '1;
    logic [W-1:0] zeros = '0;

    always #5 clk_line = ~clk_line;
    always @(posedge clk_line) cyc <= cyc + 1;

    // Default geometry: player on the oldest row.
    playfield_buf dut (
        .clk_line(clk_line), .rst_i(rst_i), .line_i(line_i),
        .scroll_en_i(scroll_en_i), .rd_row_i(rd_row_i), .rd_line_o(rd_line_o),
        .player_x_i(player_x_i), .clr_i(clr_i), .collide_o(collide_o),
        .fill_o(fill_o), .full_o(full_o)
    );

    // Player on the newest row: collision against line_i while scrolling.
    playfield_buf #(.PLAYER_ROW(0)) dut2 (
        .clk_line(clk_line), .rst_i(rst_i), .line_i(line_i),
        .scroll_en_i(scroll_en_i), .rd_row_i(rd_row_i), .rd_line_o(rd_line2),
        .player_x_i(player_x_i), .clr_i(clr_i), .collide_o(collide2),
        .fill_o(fill2), .full_o(full2)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int k);
        logic [W-1:0] v;
        for (int i = 0; i < 20; i++) begin
            v[i*32 +: 32] = 32'hC0DE_0000 + 32'(k) * 32'h0101 + 32'(i);
        end
        return v;
    endfunction

    // Open at columns 100 and 101 so only deliberate obstacles hit there.
    function automatic logic [W-1:0] mk_open(input int k);
        logic [W-1:0] v;
        v = mk(k);
        v[100] = 1'b1;
        v[101] = 1'b1;
        return v;
    endfunction

    // Expected value becomes visible at the next sampling edge.
    task automatic push(input kind_t k, input logic [W-1:0] e, input string n);
        exp_t x;
        x.cyc = cyc + 1; x.kind = k; x.exp = e; x.name = n;
        sb.push_back(x);
    endtask

    task automatic drive(input logic sc, input logic [W-1:0] ln, input logic [3:0] row,
                         input logic [9:0] x, input logic clr);
        scroll_en_i = sc; line_i = ln; rd_row_i = row; player_x_i = x; clr_i = clr;
        @(negedge clk_line);
    endtask

    // Monitor: compares whatever expectations fall due at each sampling edge.
    initial begin
        exp_t e;
        logic [W-1:0] act;
        forever begin
            @(negedge clk_line);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                act = '0;
                case (e.kind)
                    K_RD:    act = rd_line_o;
                    K_FILL:  act[4:0] = fill_o;
                    K_FULL:  act[0] = full_o;
                    K_COLL:  act[0] = collide_o;
                    K_COLL2: act[0] = collide2;
                    K_FILL2: act[4:0] = fill2;
                    default: act = 'x;
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] la, lb, lc, lx, blk, pz;

        // Async reset at time 0 region, before any clock edge.
        #1 rst_i = 1'b0;
        #2;
        check("rst_rd", rd_line_o, ones);
        check("rst_coll", W'(collide_o), W'(0));
        check("rst_fill", W'(fill_o), W'(0));
        check("rst_full", W'(full_o), W'(0));
        @(negedge clk_line);
        rst_i = 1'b1;

        // Three scrolls, then read back newest-first.
        la = mk(1); lb = mk(2); lc = mk(3);
        drive(1, la, 0, 1023, 0);
        drive(1, lb, 0, 1023, 0);
        drive(1, lc, 0, 1023, 0);
        push(K_RD, lc, "abc_row0"); drive(0, '0, 0, 1023, 0);
        push(K_RD, lb, "abc_row1"); drive(0, '0, 1, 1023, 0);
        push(K_RD, la, "abc_row2"); drive(0, '0, 2, 1023, 0);
        push(K_RD, ones, "abc_row3_unwritten");
        push(K_FILL, W'(3), "abc_fill");
        push(K_FULL, W'(0), "abc_full");
        drive(0, '0, 3, 1023, 0);

        // Twenty scrolls: buffer wraps, L0..L3 overwritten.
        for (int k = 0; k < 20; k++) drive(1, mk(100 + k), 0, 1023, 0);
        push(K_FILL, W'(16), "wrap_fill");
        push(K_FULL, W'(1), "wrap_full");
        for (int r = 0; r < 16; r++) begin
            push(K_RD, mk(100 + 19 - r), $sformatf("wrap_row%0d", r));
            drive(0, '0, 4'(r), 1023, 0);
        end

        // Read coincident with a scroll sees the pre-scroll row 0.
        lx = mk(55);
        push(K_RD, mk(119), "rdscroll_old");
        drive(1, lx, 0, 1023, 0);
        push(K_RD, lx, "rdscroll_new");
        drive(0, '0, 0, 1023, 0);

        // Obstacle at column 100 placed on row 14 of a full buffer.
        blk = '1; blk[100] = 1'b0;
        for (int k = 0; k < 16; k++) drive(1, mk_open(300 + k), 0, 1023, 0);
        drive(1, blk, 0, 1023, 0);
        for (int k = 0; k < 14; k++) drive(1, mk_open(400 + k), 0, 1023, 0);
        push(K_COLL, W'(0), "coll_row15_open");
        drive(0, '0, 0, 100, 0);
        push(K_COLL, W'(1), "coll_scroll_hit");
        drive(1, mk_open(500), 0, 100, 0);
        for (int k = 0; k < 5; k++) begin
            push(K_COLL, W'(1), $sformatf("coll_hold%0d", k));
            drive(0, '0, 0, 101, 0);
        end
        push(K_COLL, W'(0), "coll_clear");
        drive(0, '0, 0, 101, 1);
        push(K_COLL, W'(0), "coll_stays_clear");
        drive(0, '0, 0, 101, 0);

        // Set wins over clear.
        push(K_COLL, W'(1), "coll_idle_hit");
        drive(0, '0, 0, 100, 0);
        push(K_COLL, W'(1), "coll_set_wins");
        drive(0, '0, 0, 100, 1);
        push(K_COLL, W'(0), "coll_clear2");
        drive(0, '0, 0, 101, 1);

        // All-zero row under the player: out-of-range column never hits.
        drive(1, zeros, 0, 1023, 0);
        for (int k = 0; k < 15; k++) drive(1, mk_open(600 + k), 0, 1023, 0);
        for (int k = 0; k < 3; k++) begin
            push(K_COLL, W'(0), $sformatf("coll_x700_%0d", k));
            drive(0, '0, 0, 700, 0);
        end
        push(K_COLL, W'(1), "coll_x639_edge");
        drive(0, '0, 0, 639, 0);
        push(K_COLL, W'(0), "coll_clear3");
        drive(0, '0, 0, 1023, 1);

        // Fresh start, fill to 9, set the flag on the row-0 instance.
        rst_i = 1'b0;
        drive(0, '0, 0, 1023, 0);
        rst_i = 1'b1;
        for (int k = 0; k < 8; k++) drive(1, mk(700 + k), 0, 1023, 0);
        pz = mk(708); pz[5] = 1'b0;
        push(K_COLL, W'(0), "p15_row_invalid");
        push(K_COLL2, W'(1), "p0_line_hit");
        push(K_FILL, W'(9), "mid_fill");
        push(K_FILL2, W'(9), "mid_fill2");
        drive(1, pz, 0, 5, 0);

        // Asynchronous reset mid-cycle with a scroll pending.
        scroll_en_i = 1'b1; line_i = zeros; player_x_i = 10'd1023;
        #2 rst_i = 1'b0;
        #1;
        check("async_rd", rd_line_o, ones);
        check("async_coll2", W'(collide2), W'(0));
        check("async_fill", W'(fill_o), W'(0));
        check("async_full", W'(full_o), W'(0));
        check("async_fill2", W'(fill2), W'(0));
        @(negedge clk_line);
        @(negedge clk_line);
        rst_i = 1'b1;
        push(K_FILL, W'(0), "post_rst_fill");
        for (int r = 0; r < 16; r++) begin
            push(K_RD, ones, $sformatf("post_rst_row%0d", r));
            drive(0, '0, 4'(r), 1023, 0);
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk_line);
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
